sop_tag_fifo: RTL and testbench

//  Parametrised index-tag FIFO between the RMSP front end and the FFT output.

---
 rtl/sop_tag_fifo.sv | 159 +++++++++++++++
 tb/tb_sop_tag_fifo.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sop_tag_fifo.sv
// sop_tag_fifo: index-tag FIFO between the RMSP front end and the FFT output.
// A tag is captured on each input start-of-packet and replayed in order on each
// output start-of-packet, so every FFT symbol keeps its frame/symbol index.
// Optional feature macro: SOP_TAG_LAT_EN adds a free-running cycle counter,
// a per-entry push timestamp and the lat_out_o push-to-pop latency output.
module sop_tag_fifo #(
    parameter int unsigned TAG_W = 7,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       in_sop_i,
    input  logic [TAG_W-1:0]           tag_in_i,
    input  logic                       out_sop_i,
    output logic [TAG_W-1:0]           tag_out_o,
    output logic                       tag_valid_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o,
    output logic                       underflow_o
`ifdef SOP_TAG_LAT_EN
    ,
    output logic [LAT_W-1:0]           lat_out_o
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic [TAG_W-1:0] tag_out_q, tag_out_d;
    logic             tag_valid_q, tag_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [TAG_W-1:0] mem_q [DEPTH];

    logic pop_ok;
    logic push_ok;
    logic mem_we;

    // Pop decides on the pre-cycle level; a full FIFO still accepts a push
    // when a pop completes in the same cycle.
    always_comb begin
        pop_ok  = out_sop_i && (level_q != '0);
        push_ok = in_sop_i && ((level_q < LvlW'(DEPTH)) || pop_ok);
        mem_we  = push_ok && !flush_i;
    end

    // Next-state for pointers, occupancy, output tag and status pulses.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        tag_out_d   = tag_out_q;
        tag_valid_d = tag_valid_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (flush_i) begin
            // tag_out deliberately holds its last value across a flush
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            tag_valid_d = 1'b0;
        end else begin
            overflow_d  = in_sop_i && !push_ok;
            underflow_d = out_sop_i && (level_q == '0);
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d    = rd_ptr_q + PtrW'(1);
                tag_out_d   = mem_q[rd_ptr_q];
                tag_valid_d = 1'b1;
            end else if (underflow_d) begin
                tag_valid_d = 1'b0;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LvlW'(1);
                2'b01:   level_d = level_q - LvlW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Control and output state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            tag_out_q   <= '0;
            tag_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            tag_out_q   <= tag_out_d;
            tag_valid_q <= tag_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Tag storage; not reset, only entries that were pushed are ever read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= tag_in_i;
        end
    end

    assign tag_out_o   = tag_out_q;
    assign tag_valid_o = tag_valid_q;
    assign level_o     = level_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

`ifdef SOP_TAG_LAT_EN
    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [LAT_W-1:0] stamp_q [DEPTH];

    // Latency result updates only on a successful pop; flush/underflow hold it.
    always_comb begin
        lat_d = lat_q;
        if (!flush_i && pop_ok) begin
            lat_d = cnt_q - stamp_q[rd_ptr_q];
        end
    end

    // Free-running cycle counter and latency register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            lat_q <= '0;
        end else begin
            cnt_q <= cnt_q + LAT_W'(1);
            lat_q <= lat_d;
        end
    end

    // Push timestamps, written alongside the tag.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            stamp_q[wr_ptr_q] <= cnt_q;
        end
    end

    assign lat_out_o = lat_q;
`else
    logic unused_lat_w;
    assign unused_lat_w = ^LAT_W;
`endif

endmodule

// File: tb/tb_sop_tag_fifo.sv
// Testbench for sop_tag_fifo: directed vector table, queue-based reference model
// under random traffic, asynchronous reset and (with SOP_TAG_LAT_EN) latency.
module tb_sop_tag_fifo;

    localparam int unsigned TAG_W = 7;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT_W = 16;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_sop;
    logic [TAG_W-1:0] tag_in;
    logic             out_sop;
    logic [TAG_W-1:0] tag_out;
    logic             tag_valid;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic             underflow;
`ifdef SOP_TAG_LAT_EN
    logic [LAT_W-1:0] lat_out;
`endif

    sop_tag_fifo #(
        .TAG_W(TAG_W),
        .DEPTH(DEPTH),
        .LAT_W(LAT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush),
        .in_sop_i   (in_sop),
        .tag_in_i   (tag_in),
        .out_sop_i  (out_sop),
        .tag_out_o  (tag_out),
        .tag_valid_o(tag_valid),
        .level_o    (level),
        .overflow_o (overflow),
        .underflow_o(underflow)
`ifdef SOP_TAG_LAT_EN
        ,
        .lat_out_o  (lat_out)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: plain queue of {tag, push cycle}.
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [LAT_W-1:0] stamp;
    } entry_t;
    entry_t           mq[$];
    logic [TAG_W-1:0] m_tag;
    logic             m_valid;
    logic             m_ovf;
    logic             m_unf;
    logic [LAT_W-1:0] m_lat;
    logic [LAT_W-1:0] m_cyc;

    typedef struct {
        logic             f;
        logic             i;
        logic [TAG_W-1:0] t;
        logic             o;
        logic [TAG_W-1:0] e_tag;
        logic             e_valid;
        logic [LVL_W-1:0] e_level;
        logic             e_ovf;
        logic             e_unf;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_tag   = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_lat   = '0;
        m_cyc   = '0;
    endtask

    // One clock: drive inputs, clock edge, advance model, settle 1 time unit.
    task automatic step(input logic f, input logic i, input logic [TAG_W-1:0] t, input logic o);
        int     sz;
        logic   pop;
        logic   push;
        entry_t e;
        flush   = f;
        in_sop  = i;
        tag_in  = t;
        out_sop = o;
        @(posedge clk);
        sz   = mq.size();
        pop  = o && (sz > 0);
        push = i && ((sz < DEPTH) || pop);
        if (f) begin
            mq.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            m_ovf = i && !push;
            m_unf = o && (sz == 0);
            if (pop) begin
                e       = mq.pop_front();
                m_tag   = e.tag;
                m_valid = 1'b1;
                m_lat   = m_cyc - e.stamp;
            end else if (m_unf) begin
                m_valid = 1'b0;
            end
            if (push) mq.push_back('{tag: t, stamp: m_cyc});
        end
        m_cyc = m_cyc + 1'b1;
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".tag_out"},   32'(tag_out),   32'(m_tag));
        chk({tag, ".tag_valid"}, 32'(tag_valid), 32'(m_valid));
        chk({tag, ".level"},     32'(level),     32'(mq.size()));
        chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
`ifdef SOP_TAG_LAT_EN
        chk({tag, ".lat_out"},   32'(lat_out),   32'(m_lat));
`endif
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".tag_out"},   32'(tag_out),   0);
        chk({tag, ".tag_valid"}, 32'(tag_valid), 0);
        chk({tag, ".level"},     32'(level),     0);
        chk({tag, ".overflow"},  32'(overflow),  0);
        chk({tag, ".underflow"}, 32'(underflow), 0);
`ifdef SOP_TAG_LAT_EN
        chk({tag, ".lat_out"},   32'(lat_out),   0);
`endif
    endtask

    task automatic add(input logic f, input logic i, input int t, input logic o,
                       input int et, input logic ev, input int el, input logic eo,
                       input logic eu);
        vecs.push_back('{f: f, i: i, t: TAG_W'(t), o: o, e_tag: TAG_W'(et), e_valid: ev,
                         e_level: LVL_W'(el), e_ovf: eo, e_unf: eu});
    endtask

    initial begin
        //  f  i  tag o   tag v lvl ovf unf
        add(0, 1, 5,  0,  0,  0, 1, 0, 0);   // order: push 5,6,7
        add(0, 1, 6,  0,  0,  0, 2, 0, 0);
        add(0, 1, 7,  0,  0,  0, 3, 0, 0);
        add(0, 0, 0,  1,  5,  1, 2, 0, 0);   // pops return 5,6,7
        add(0, 0, 0,  1,  6,  1, 1, 0, 0);
        add(0, 0, 0,  1,  7,  1, 0, 0, 0);
        add(0, 1, 1,  0,  7,  1, 1, 0, 0);   // fill with 1..4
        add(0, 1, 2,  0,  7,  1, 2, 0, 0);
        add(0, 1, 3,  0,  7,  1, 3, 0, 0);
        add(0, 1, 4,  0,  7,  1, 4, 0, 0);
        add(0, 1, 5,  0,  7,  1, 4, 1, 0);   // 5th push dropped
        add(0, 0, 0,  0,  7,  1, 4, 0, 0);   // overflow is a single pulse
        add(0, 1, 9,  1,  1,  1, 4, 0, 0);   // full + push + pop
        add(0, 0, 0,  1,  2,  1, 3, 0, 0);
        add(0, 0, 0,  1,  3,  1, 2, 0, 0);
        add(0, 0, 0,  1,  4,  1, 1, 0, 0);
        add(0, 0, 0,  1,  9,  1, 0, 0, 0);   // 9 comes out last
        add(0, 0, 0,  1,  9,  0, 0, 0, 1);   // pop on empty
        add(0, 0, 0,  0,  9,  0, 0, 0, 0);   // underflow is a single pulse
        add(0, 1, 3,  1,  9,  0, 1, 0, 1);   // empty + push + pop
        add(0, 0, 0,  1,  3,  1, 0, 0, 0);
        add(0, 1, 127, 0, 3,  1, 1, 0, 0);   // tag value extremes
        add(0, 1, 0,  0,  3,  1, 2, 0, 0);
        add(0, 0, 0,  1,  127, 1, 1, 0, 0);
        add(0, 0, 0,  1,  0,  1, 0, 0, 0);
        add(0, 1, 10, 0,  0,  1, 1, 0, 0);
        add(0, 1, 11, 0,  0,  1, 2, 0, 0);
        add(1, 0, 0,  0,  0,  0, 0, 0, 0);   // flush at level 2
        add(0, 0, 0,  1,  0,  0, 0, 0, 1);   // next pop underflows
        add(0, 1, 20, 0,  0,  0, 1, 0, 0);
        add(1, 1, 21, 1,  0,  0, 0, 0, 0);   // flush beats push and pop
        add(0, 0, 0,  1,  0,  0, 0, 0, 1);

        rst_n   = 1'b0;
        flush   = 1'b0;
        in_sop  = 1'b0;
        tag_in  = '0;
        out_sop = 1'b0;
        #1;
        check_zero("reset0");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].f, vecs[k].i, vecs[k].t, vecs[k].o);
            chk($sformatf("vec%0d.tag_out", k),   32'(tag_out),   32'(vecs[k].e_tag));
            chk($sformatf("vec%0d.tag_valid", k), 32'(tag_valid), 32'(vecs[k].e_valid));
            chk($sformatf("vec%0d.level", k),     32'(level),     32'(vecs[k].e_level));
            chk($sformatf("vec%0d.overflow", k),  32'(overflow),  32'(vecs[k].e_ovf));
            chk($sformatf("vec%0d.underflow", k), 32'(underflow), 32'(vecs[k].e_unf));
        end

        // Pointer wrap: 3*DEPTH lock-step push/pop cycles with one entry buffered.
        step(0, 1, 7'd100, 0);
        for (int k = 0; k < 3 * DEPTH; k++) begin
            step(0, 1, TAG_W'(k + 120), 1);
            check_model($sformatf("wrap%0d", k));
        end
        step(0, 0, 0, 1);
        check_model("wrap_drain");

`ifdef SOP_TAG_LAT_EN
        // Push at t, pop at t+37.
        step(0, 1, 7'd55, 0);
        repeat (36) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("lat37.lat_out", 32'(lat_out), 37);
        chk("lat37.tag_out", 32'(tag_out), 55);
        step(0, 0, 0, 1);
        chk("lat_hold_unf.lat_out", 32'(lat_out), 37);
`endif

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
                 TAG_W'($urandom), $urandom_range(0, 1) == 1);
            check_model($sformatf("rnd%0d", k));
        end

        // Asynchronous reset mid-traffic: outputs clear without a clock edge.
        step(0, 1, 7'd33, 0);
        step(0, 1, 7'd34, 1);
        step(0, 1, 7'd35, 0);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        flush   = 1'b0;
        in_sop  = 1'b0;
        out_sop = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        step(0, 0, 0, 0);
        check_model("post_rst");
        step(0, 0, 0, 1);
        check_model("post_rst_pop");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
